// File: rtl/dom_rand_pkg.sv
// dom_rand_pkg: shared constants, FSM states and single LFSR step for the DOM randomness source
package dom_rand_pkg;
    localparam int LFSR_W = 32;
    localparam logic [LFSR_W-1:0] TAPS = 32'h80200003;
    localparam logic [LFSR_W-1:0] SEED_FALLBACK = 32'h00000001;
    typedef enum logic [1:0] {IDLE, WARM, RUN} state_t;
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction
endpackage

// File: rtl/dom_rand_lfsr_adv.sv
// dom_rand_lfsr_adv: applies the Galois LFSR step RAND_W times in one combinational pass
module dom_rand_lfsr_adv
    import dom_rand_pkg::*;
#(
    parameter int RAND_W = 1
) (
    input  logic [LFSR_W-1:0] lfsr,
    output logic [LFSR_W-1:0] lfsr_next
);
    always_comb begin
        lfsr_next = lfsr;
        for (int i = 0; i < RAND_W; i++) lfsr_next = lfsr_step(lfsr_next);
    end
endmodule

// File: rtl/dom_rand_source.sv
// dom_rand_source: seeded LFSR feeding DOM gadgets, with warm-up gating and one word per consume
module dom_rand_source
    import dom_rand_pkg::*;
#(
    parameter int RAND_W = 1,
    parameter int WARMUP = 64
) (
    input  logic              clock_0,
    input  logic              reset_0,
    input  logic              io_seed_valid,
    input  logic [LFSR_W-1:0] io_seed,
    output logic              io_seed_ready,
    input  logic              io_en,
    output logic [RAND_W-1:0] io_rand,
    output logic              io_rand_valid
);
    localparam int CNT_W = WARMUP > 1 ? $clog2(WARMUP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP > 0 ? WARMUP - 1 : 0);
    state_t state;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_adv;
    logic [CNT_W-1:0] cnt;
    logic accept;
    assign accept = io_seed_valid & io_seed_ready;
    assign io_rand = lfsr[RAND_W-1:0];
    dom_rand_lfsr_adv #(.RAND_W(RAND_W)) u_adv (
        .lfsr     (lfsr),
        .lfsr_next(lfsr_adv)
    );
    // a seed wins over a simultaneous io_en: the old word is discarded, never advanced
    always_ff @(posedge clock_0) begin
        if (reset_0) begin
            state         <= IDLE;
            lfsr          <= '0;
            cnt           <= '0;
            io_seed_ready <= 1'b1;
            io_rand_valid <= 1'b0;
        end else if (accept) begin
            lfsr          <= io_seed == '0 ? SEED_FALLBACK : io_seed;
            cnt           <= '0;
            state         <= WARMUP > 0 ? WARM : RUN;
            io_seed_ready <= WARMUP == 0;
            io_rand_valid <= WARMUP == 0;
        end else if (state == WARM) begin
            lfsr <= lfsr_adv;
            cnt  <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
                state         <= RUN;
                io_seed_ready <= 1'b1;
                io_rand_valid <= 1'b1;
            end
        end else if (state == RUN && io_en) begin
            lfsr <= lfsr_adv;
        end
    end
endmodule
